// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder and slave-response multiplexer for a single-master bus.
// A built-in default slave answers unmapped active transfers with a two-cycle ERROR.
module ahblite_decoder_mux #(
  parameter int                  NPORT     = 4,
  parameter logic [NPORT*32-1:0] PORT_BASE = {32'h4001_0000, 32'h4000_0000,
                                              32'h2000_0000, 32'h0000_0000},
  parameter logic [NPORT*32-1:0] PORT_MASK = {32'hFFFF_0000, 32'hFFFF_0000,
                                              32'hFFFF_C000, 32'hFFFF_C000},
  parameter logic [NPORT-1:0]    PORT_EN   = {NPORT{1'b1}}
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NPORT-1:0]      HSEL,
  input  logic [NPORT*32-1:0]   HRDATA_S,
  input  logic [NPORT-1:0]      HREADYOUT_S,
  input  logic [NPORT-1:0]      HRESP_S,
  output logic [31:0]           HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [7:0]            DECERR_CNT,
  output logic [31:0]           DECERR_ADDR
);

  localparam int IDXW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  logic [NPORT-1:0] hit_s;
  logic [NPORT-1:0] hsel_s;
  logic [IDXW-1:0]  hit_idx_s;
  logic             mapped_s;

  logic             sel_valid_q, sel_valid_d;
  logic [IDXW-1:0]  sel_idx_q, sel_idx_d;
  ds_state_e        ds_state_q, ds_state_d;
  logic [7:0]       decerr_cnt_q, decerr_cnt_d;
  logic [31:0]      decerr_addr_q, decerr_addr_d;

  logic [31:0]      slv_rdata_s;
  logic             slv_ready_s;
  logic             slv_resp_s;
  logic             hready_s;
  logic             hresp_s;
  logic [31:0]      hrdata_s;
  logic             new_err_s;
  logic             err_start_s;
  logic             unused_s;

  // Window match per port; disabled ports never hit.
  always_comb begin
    hit_s = '0;
    for (int n = 0; n < NPORT; n++) begin
      hit_s[n] = PORT_EN[n] &
                 ((HADDR & PORT_MASK[32*n +: 32]) == PORT_BASE[32*n +: 32]);
    end
  end

  // Isolating the lowest set bit gives lowest-index priority on overlapping windows.
  always_comb begin
    hsel_s    = hit_s & (~hit_s + NPORT'(1'b1));
    mapped_s  = |hit_s;
    hit_idx_s = '0;
    for (int n = 0; n < NPORT; n++) begin
      hit_idx_s = hit_idx_s | (hsel_s[n] ? IDXW'(n) : {IDXW{1'b0}});
    end
  end

  // Data-phase response from the selected slave port.
  always_comb begin
    slv_rdata_s = 32'h0000_0000;
    slv_ready_s = 1'b0;
    slv_resp_s  = 1'b0;
    for (int n = 0; n < NPORT; n++) begin
      slv_rdata_s = slv_rdata_s | ((sel_idx_q == IDXW'(n)) ? HRDATA_S[32*n +: 32] : 32'h0000_0000);
      slv_ready_s = slv_ready_s | ((sel_idx_q == IDXW'(n)) & HREADYOUT_S[n]);
      slv_resp_s  = slv_resp_s  | ((sel_idx_q == IDXW'(n)) & HRESP_S[n]);
    end
  end

  // Final mux between a mapped slave and the default slave.
  always_comb begin
    hready_s = sel_valid_q ? slv_ready_s : (ds_state_q != DS_ERR1);
    hresp_s  = sel_valid_q ? slv_resp_s  : (ds_state_q != DS_IDLE);
    hrdata_s = sel_valid_q ? slv_rdata_s : 32'h0000_0000;
  end

  // Select register only moves when the current data phase completes.
  always_comb begin
    sel_valid_d = hready_s ? mapped_s  : sel_valid_q;
    sel_idx_d   = hready_s ? hit_idx_s : sel_idx_q;
  end

  // Default-slave FSM; a mapped data phase pulls it back to IDLE.
  always_comb begin
    new_err_s  = HTRANS[1] & ~mapped_s;
    ds_state_d = DS_IDLE;
    case (ds_state_q)
      DS_IDLE: ds_state_d = (hready_s && new_err_s) ? DS_ERR1 : DS_IDLE;
      DS_ERR1: ds_state_d = sel_valid_q ? DS_IDLE : DS_ERR2;
      DS_ERR2: ds_state_d = (!sel_valid_q && new_err_s) ? DS_ERR1 : DS_IDLE;
      default: ds_state_d = DS_IDLE;
    endcase
    err_start_s = (ds_state_d == DS_ERR1);
  end

  // Fault capture on every entry into ERR1; the count saturates.
  always_comb begin
    decerr_cnt_d  = (err_start_s && (decerr_cnt_q != 8'hFF)) ? (decerr_cnt_q + 8'd1) : decerr_cnt_q;
    decerr_addr_d = err_start_s ? HADDR : decerr_addr_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_valid_q   <= 1'b0;
      sel_idx_q     <= '0;
      ds_state_q    <= DS_IDLE;
      decerr_cnt_q  <= 8'h00;
      decerr_addr_q <= 32'h0000_0000;
    end else begin
      sel_valid_q   <= sel_valid_d;
      sel_idx_q     <= sel_idx_d;
      ds_state_q    <= ds_state_d;
      decerr_cnt_q  <= decerr_cnt_d;
      decerr_addr_q <= decerr_addr_d;
    end
  end

  assign HSEL        = hsel_s;
  assign HREADY      = hready_s;
  assign HRESP       = hresp_s;
  assign HRDATA      = hrdata_s;
  assign DECERR_CNT  = decerr_cnt_q;
  assign DECERR_ADDR = decerr_addr_q;
  // IDLE and BUSY are treated alike, so only HTRANS[1] matters.
  assign unused_s    = HTRANS[0];

endmodule

// File: doc/ahblite_decoder_mux.md
# ahblite_decoder_mux

Parametrised AHB-Lite address decoder and slave-response multiplexer for the Cortex-M0 bus: it decodes HADDR against NPORT programmable base/mask windows, drives per-port HSEL in the address phase, and routes the selected slave's HRDATA, HREADYOUT and HRESP back to the master in the data phase.
It contains a built-in default slave that gives the AHB two-cycle ERROR response for unmapped active transfers, and it records decode faults for debug.
It sits between the single M0 master and the RAMCODE, RAMDATA and peripheral slaves.

## Interface
- NPORT, 4, number of slave ports, 1..8
- PORT_BASE, {32'h40010000,32'h40000000,32'h20000000,32'h00000000}, NPORT×32 packed; port n base at [32n+31:32n]
- PORT_MASK, {32'hFFFF0000,32'hFFFF0000,32'hFFFFC000,32'hFFFFC000}, NPORT×32 packed; port n hits when (HADDR & MASK_n) == BASE_n
- PORT_EN, {NPORT{1'b1}}, per-port enable; a disabled port never hits
- HCLK  in  1  bus clock; all state on rising edge
- HRESET  in  1  synchronous, active-high reset
- HADDR  in  32  master address-phase address
- HTRANS  in  2  master transfer type
- HSEL  out  NPORT  one-hot address-phase slave selects
- HRDATA_S  in  NPORT×32  slave read data, packed like PORT_BASE
- HREADYOUT_S  in  NPORT  slave ready outputs
- HRESP_S  in  NPORT  slave responses
- HRDATA  out  32  muxed read data to master
- HREADY  out  1  muxed ready, to master and to all slaves' HREADY
- HRESP  out  1  muxed response to master
- DECERR_CNT  out  8  saturating count of default-slave ERROR responses
- DECERR_ADDR  out  32  HADDR of the most recent unmapped active transfer

## Operation
Address decode:
- HSEL is combinational from HADDR and is independent of HTRANS.
- If several windows hit, the lowest index wins, so HSEL is always one-hot or zero.
- "Unmapped" means no port hits.

Data-phase select:
- A register holds {valid, port index}. It loads the decode result on each HCLK edge where HREADY=1.
- Unmapped addresses load the default-slave code.
- Mapped port p: HRDATA=HRDATA_S[p], HREADY=HREADYOUT_S[p], HRESP=HRESP_S[p].
- Default slave: HRDATA=0. HREADY and HRESP come from the default-slave FSM.

Default-slave FSM, states IDLE, ERR1, ERR2:
- IDLE: HREADY=1, HRESP=0.
  - Go to ERR1 when HREADY=1, HTRANS[1]=1 and the address is unmapped.
  - IDLE or BUSY to an unmapped address gives a zero-wait OKAY and stays in IDLE.
- ERR1: HREADY=0, HRESP=1. Always go to ERR2.
- ERR2: HREADY=1, HRESP=1.
  - Go to ERR1 if a new unmapped NONSEQ/SEQ is presented in this cycle.
  - Otherwise go to IDLE.
- The FSM advances only while the data-phase select is the default slave. A mapped data phase forces IDLE.

Fault recording:
- On each IDLE→ERR1 or ERR2→ERR1 transition: DECERR_ADDR ← HADDR, and DECERR_CNT increments.
- DECERR_CNT saturates at 8'hFF.

## Timing
Reset values:
- Select register: default slave, non-active.
- FSM: IDLE.
- HREADY=1, HRESP=0, HRDATA=0, DECERR_CNT=0, DECERR_ADDR=0.
- HSEL follows HADDR even during reset.

Latency:
- HSEL: 0 cycles, combinational.
- Response mux: switches on the edge that ends the address phase.
- Unmapped error: 2 data-phase cycles, then HREADY=1.

Boundary conditions:
- Wait states: when a slave holds HREADYOUT=0, the select register must not update. A back-to-back address to another port stays pending.
- HRESET asserted mid-ERR1: the next cycle is IDLE with HREADY=1, HRESP=0.
- NPORT=1 must elaborate. Only port 0 decodes.

## Test plan
- Decode map: HADDR=0x00003FFC, 0x00004000, 0x20000010, 0x40000000, 0x4001FFFC → HSEL=0001, 0000, 0010, 0100, 1000.
- Read mux with wait state: NONSEQ to 0x20000010; port 1 HREADYOUT=0 for 2 cycles, then data 0xDEADBEEF → HREADY low 2 cycles; HRDATA=0xDEADBEEF when HREADY=1; next address held.
- Unmapped error: NONSEQ to 0x30000000 → HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then IDLE; DECERR_ADDR=0x30000000, DECERR_CNT=1.
- Error cases: back-to-back unmapped NONSEQs at 0x30000000 and 0x50000000 → ERR1,ERR2,ERR1,ERR2; DECERR_CNT=2; DECERR_ADDR=0x50000000. HTRANS=IDLE to unmapped → OKAY, no count.
- Saturation: 300 unmapped NONSEQs → DECERR_CNT=0xFF.
- Config: PORT_EN=4'b1011 with 0x40000000 → unmapped ERROR. Overlap with port 2 base/mask = 0x40000000/0xFFFE0000 and address 0x40010000 → HSEL=0100, ports 2 and 3 overlap, lowest index wins.
- Reset: HRESET asserted during ERR1 → next cycle HREADY=1, HRESP=0, DECERR_CNT=0.
